// File: rtl/decode_unpack_pkg.sv
// Shared types and defaults for the LZS bit-stream unpacker.
// FSM states, default widths and a bits-mod-8 helper.
package decode_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int DEF_IN_W   = 64;
    localparam int DEF_LANE_W = 16;
    localparam int DEF_PEEK_W = 13;

    function automatic logic [2:0] mod8(input int unsigned bits);
        return 3'(bits % 8);
    endfunction

endpackage

// File: rtl/decode_unpack_if.sv
// Word input and token-parser peek/consume bundle for decode_unpack.
// master = producer/parser side, slave = the unpacker.
interface decode_unpack_if
    import decode_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int LANE_W = DEF_LANE_W,
    parameter int PEEK_W = DEF_PEEK_W
);
    localparam int CW = $clog2(PEEK_W + 1);
    localparam int BW = $clog2(2 * LANE_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_last;
    logic [PEEK_W-1:0] out_data;
    logic              out_valid;
    logic [BW-1:0]     out_bits;
    logic              take;
    logic [CW-1:0]     take_width;
    logic              align;
    logic              done;
    logic              err_over;

    modport master (
        output in_valid, in_data, in_last, take, take_width, align,
        input  in_ready, out_data, out_valid, out_bits, done, err_over
    );

    modport slave (
        input  in_valid, in_data, in_last, take, take_width, align,
        output in_ready, out_data, out_valid, out_bits, done, err_over
    );
endinterface

// File: rtl/decode_unpack_wbuf.sv
// Single-word buffer that hands out LANE_W lanes in stream order.
// A new word may land on the edge its predecessor's last lane leaves.
module decode_unpack_wbuf
    import decode_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [IN_W-1:0]   in_data,
    input  logic              open,
    input  logic              refill,
    output logic              in_ready,
    output logic              lane_valid,
    output logic              lane_last,
    output logic [LANE_W-1:0] lane
);
    localparam int NL = IN_W / LANE_W;
    localparam int LB = LANE_W / 8;
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;

    logic [IN_W-1:0]            word;
    logic [IW-1:0]              idx;
    logic                       full;
    logic                       last;
    logic                       last_lane;
    logic                       accept;
    logic [NL-1:0][LANE_W-1:0]  lanes;

    assign last_lane  = (idx == IW'(NL - 1));
    assign lane_valid = full;
    assign lane_last  = last && last_lane;
    // A closing word blocks further input until the stream restarts.
    assign in_ready   = open && (!full || (!last && refill && last_lane));
    assign accept     = in_valid && in_ready;
    assign lane       = lanes[idx];

    // Reorder bytes so the earliest stream byte sits at the lane MSB.
    always_comb begin
        lanes = '0;
        for (int j = 0; j < NL; j++)
            for (int k = 0; k < LB; k++)
                lanes[j][LANE_W-1-8*k -: 8] = word[8*(j*LB+k) +: 8];
    end

    // Load a word on accept, otherwise step the lane index per refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx  <= '0;
            full <= 1'b0;
            last <= 1'b0;
        end else if (accept) begin
            word <= in_data;
            idx  <= '0;
            full <= 1'b1;
            last <= in_last;
        end else if (refill) begin
            if (last_lane) begin
                full <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/decode_unpack.sv
// LZS decode bit-stream unpacker: word buffer -> 2-lane shift window.
// Optional byte realignment when DECODE_UNPACK_ALIGN_EN is defined.
module decode_unpack
    import decode_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int LANE_W = DEF_LANE_W,
    parameter int PEEK_W = DEF_PEEK_W
) (
    input logic            clk,
    input logic            rst,
    decode_unpack_if.slave bus
);
    localparam int SREG_W = 2 * LANE_W;
    localparam int BW     = $clog2(SREG_W + 1);

    state_t             state, state_nx;
    logic [SREG_W-1:0]  sreg, s_take, s_align, sreg_nx, lane_top;
    logic [BW-1:0]      cnt, c_take, c_align, cnt_nx, n_take;
    logic [2:0]         n_align;
    logic               over, refill, accept, done_q, err_q;
    logic               lane_valid, lane_last;
    logic [LANE_W-1:0]  lane;

    decode_unpack_wbuf #(
        .IN_W   (IN_W),
        .LANE_W (LANE_W)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (bus.in_valid),
        .in_last    (bus.in_last),
        .in_data    (bus.in_data),
        .open       (state != DRAIN),
        .refill     (refill),
        .in_ready   (bus.in_ready),
        .lane_valid (lane_valid),
        .lane_last  (lane_last),
        .lane       (lane)
    );

    assign accept   = bus.in_valid && bus.in_ready;
    assign lane_top = {lane, {LANE_W{1'b0}}};

    // Window update: consume, optional byte align, then one-lane refill.
    always_comb begin
        over    = bus.take && (BW'(bus.take_width) > cnt);
        n_take  = !bus.take ? '0 : (over ? cnt : BW'(bus.take_width));
        s_take  = sreg << n_take;
        c_take  = cnt - n_take;
`ifdef DECODE_UNPACK_ALIGN_EN
        n_align = bus.align ? mod8(32'(c_take)) : 3'd0;
`else
        n_align = 3'd0;
`endif
        s_align = s_take << n_align;
        c_align = c_take - BW'(n_align);
        refill  = lane_valid && (c_align <= BW'(SREG_W - LANE_W));
        sreg_nx = refill ? (s_align | (lane_top >> c_align)) : s_align;
        cnt_nx  = refill ? (c_align + BW'(LANE_W)) : c_align;
    end

    // Stream lifecycle: start on first word, drain after last lane.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (refill && lane_last) state_nx = DRAIN;
            DRAIN:   if (cnt_nx == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Window, FSM, done pulse and sticky over-consume flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            sreg   <= sreg_nx;
            cnt    <= cnt_nx;
            done_q <= (state == DRAIN) && (cnt_nx == '0);
            err_q  <= err_q | over;
        end
    end

    assign bus.out_data  = sreg[SREG_W-1 -: PEEK_W];
    assign bus.out_bits  = cnt;
    assign bus.out_valid = (cnt >= BW'(PEEK_W)) ||
                           ((state == DRAIN) && (cnt != '0));
    assign bus.done      = done_q;
    assign bus.err_over  = err_q;
endmodule

// File: tb/tb_decode_unpack.sv
// Scoreboard bench for decode_unpack: reference bit queue vs window.
// Define DECODE_UNPACK_ALIGN_EN for both RTL and bench to test align.
module tb_decode_unpack;
    import decode_pkg::*;

    localparam int IN_W   = 64;
    localparam int LANE_W = 16;
    localparam int PEEK_W = 13;
    localparam int CW     = $clog2(PEEK_W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_unpack_if #(
        .IN_W(IN_W), .LANE_W(LANE_W), .PEEK_W(PEEK_W)
    ) bus ();

    decode_unpack #(
        .IN_W(IN_W), .LANE_W(LANE_W), .PEEK_W(PEEK_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit sb[$];
    logic [63:0] wq[$];
    bit lq[$];

    always @(posedge clk) if (!rst && bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PEEK_W-1:0] exp_peek();
        logic [PEEK_W-1:0] v;
        v = '0;
        for (int i = 0; i < PEEK_W; i++)
            if (i < sb.size()) v[PEEK_W-1-i] = sb[i];
        return v;
    endfunction

    task automatic push_word(input logic [63:0] w);
        for (int b = 0; b < 8; b++)
            for (int k = 7; k >= 0; k--)
                sb.push_back(w[8*b+k]);
    endtask

    task automatic idle_in();
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.take       = 1'b0;
        bus.take_width = '0;
        bus.align      = 1'b0;
    endtask

    // One cycle: drive at negedge, score, then advance to next negedge.
    task automatic step(input logic tk, input int tw, input logic al);
        int n;
        bus.take       = tk;
        bus.take_width = CW'(tw);
        bus.align      = al;
        bus.in_valid   = (wq.size() != 0);
        bus.in_data    = (wq.size() != 0) ? wq[0] : '0;
        bus.in_last    = (lq.size() != 0) ? lq[0] : 1'b0;
        #1;
        if (tk && bus.out_valid) chk("data", bus.out_data, exp_peek());
        if (tk) begin
            n = (tw < sb.size()) ? tw : sb.size();
            repeat (n) void'(sb.pop_front());
`ifdef DECODE_UNPACK_ALIGN_EN
            if (al) repeat (sb.size() % 8) void'(sb.pop_front());
`endif
        end
        if (bus.in_valid && bus.in_ready) begin
            push_word(wq.pop_front());
            void'(lq.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        idle_in();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, bus.in_ready, 1);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_bits"}, bus.out_bits, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err_over, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int guard;
        idle_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;

        wq.push_back(64'hF0DE_BC9A_7856_3412);
        lq.push_back(1'b0);
        step(0, 0, 0);
        chk("pre_valid", bus.out_valid, 0);
        step(0, 0, 0);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_data", bus.out_data, 13'h0246);
        chk("lat_bits", bus.out_bits, 16);
        step(0, 0, 0);
        chk("bits32", bus.out_bits, 32);

        for (int i = 0; i < 4; i++) begin
            wq.push_back({$urandom, $urandom});
            lq.push_back(1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            chk("no_gap", bus.out_valid, 1);
            step(1, 13, 0);
        end
        chk("fed", wq.size(), 0);

        rst = 1'b1;
        wq.delete();
        lq.delete();
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset("mid");
        rst = 1'b0;

        wq.push_back(64'h0123_4567_89AB_CDEF);
        lq.push_back(1'b1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pre_align", bus.out_bits, 32);
        step(1, 7, 1);
`ifdef DECODE_UNPACK_ALIGN_EN
        chk("align_bits", bus.out_bits, 24);
        chk("align_mod8", bus.out_bits % 8, 0);
`else
        chk("noalign_bits", bus.out_bits, 25);
`endif
        chk("align_data", bus.out_data, exp_peek());

        guard = 0;
        while (bus.out_bits >= 13 && guard < 20) begin
            step(1, 13, 0);
            guard++;
        end
        chk("drain_bound", guard < 20, 1);
        chk("drain_valid", bus.out_valid, 1);
        chk("drain_bits", bus.out_bits, sb.size());
        chk("zero_fill", bus.out_data, exp_peek());
        chk("fill_low", bus.out_data & 13'h00FF, 0);
        chk("done_before", done_cnt, 0);

        step(1, 13, 0);
        chk("over_bits", bus.out_bits, 0);
        chk("err_set", bus.err_over, 1);
        chk("done_pulse", bus.done, 1);
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_ready", bus.in_ready, 1);
        step(0, 0, 0);
        chk("done_low", bus.done, 0);
        chk("done_once", done_cnt, 1);
        chk("err_sticky", bus.err_over, 1);

        wq.push_back(64'hDEAD_BEEF_CAFE_F00D);
        lq.push_back(1'b0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("new_valid", bus.out_valid, 1);
        step(1, 13, 0);
        step(1, 3, 0);
        step(1, 13, 0);
        step(1, 13, 0);
        chk("err_keep", bus.err_over, 1);
        chk("done_total", done_cnt, 1);

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("end");
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_unpack.md
# decode_unpack

Parametrised bit-stream unpacker for the LZS decode path; successor to the fixed 64→16-bit input stage. Accepts IN_W-bit words over a valid/ready handshake, splits them into LANE_W-bit lanes, and keeps a shift window from which the token parser peeks PEEK_W bits and consumes 0..PEEK_W bits per cycle. Adds what the fixed stage lacked: an end-of-stream drain with a done pulse, byte realignment for stored blocks, and over-consume detection.

## Interface
- IN_W, 64, input word width; multiple of LANE_W.
- LANE_W, 16, refill granule; multiple of 8. SREG_W = 2*LANE_W is the window width.
- PEEK_W, 13, peek width; 1 ≤ PEEK_W ≤ LANE_W.
- CW, $clog2(PEEK_W+1), width of take_width.
- BW, $clog2(SREG_W+1), width of out_bits.
- clk  in  1  clock. The block uses one clock.
- rst  in  1  reset. Synchronous, active-high.
- in_valid  in  1  in_data and in_last are valid.
- in_ready  out  1  the word buffer can accept a word.
- in_data  in  IN_W  stream bytes; byte k is at [8k+7:8k]; byte 0 comes first in the stream.
- in_last  in  1  the word is the final word of the stream.
- out_data  out  PEEK_W  next stream bits, MSB-first = window[SREG_W-1 -: PEEK_W].
- out_valid  out  1  out_bits ≥ PEEK_W, or draining with out_bits > 0.
- out_bits  out  BW  number of valid bits in the window.
- take  in  1  consume take_width bits this cycle.
- take_width  in  CW  bits to consume.
- align  in  1  discard (out_bits mod 8) bits after the take.
- done  out  1  one-cycle pulse when the drain completes.
- err_over  out  1  sticky flag: a take exceeded out_bits.

## Operation
- FSM states:
  - IDLE → RUN on the first accepted word.
  - RUN → DRAIN when the last lane of an in_last word is appended.
  - DRAIN → IDLE when out_bits reaches 0; done pulses on that edge.
- Word buffer: one IN_W register, a lane index and a full flag. Lane j = bytes {2j..} of the word, placed MSB-first into the window.
- Per-cycle window update, in this order:
  1. Consume: shift left by min(take_width, out_bits).
  2. Align: discard further bits until the count is a multiple of 8.
  3. Refill: if the resulting count ≤ SREG_W−LANE_W and a lane is available, OR the lane in at bit position SREG_W−count−LANE_W, add LANE_W to the count and advance the lane index. Maximum one lane per cycle.
- take with take_width > out_bits:
  - consume all bits and set err_over;
  - err_over clears only on rst.
- take with take_width = 0: no shift; align still applies.
- in_ready = !full || (last lane is being refilled this cycle). A word can be accepted on the same edge the previous word empties.
- in_valid is ignored in DRAIN. The next stream starts only after returning to IDLE.
- In DRAIN, out_valid holds with fewer than PEEK_W bits. Bits below out_bits are zero-filled.

## Timing
- Reset values: in_ready=1, out_valid=0, out_bits=0, out_data=0, done=0, err_over=0, state IDLE, buffer empty.
- Latency:
  - word accepted at edge N → first lane in window at edge N+1;
  - out_valid high in cycle N+1 when LANE_W ≥ PEEK_W;
  - second lane at N+2.
- Throughput: sustained consumption of up to LANE_W bits/cycle without a gap, provided in_valid keeps up.
- rst mid-stream aborts on the next edge. Partial data is discarded and no done pulse is generated.
- take, align and a word accept in the same cycle are legal and all take effect on that edge.
- out_* are registered; out_data and out_bits depend only on state, never on take.

## Configuration
- DECODE_UNPACK_ALIGN_EN:
  - defined: align works as specified;
  - undefined: the align input is ignored and the alignment logic is not built.

## Structure
- Shared package decode_pkg holds:
  - the FSM state typedef (IDLE/RUN/DRAIN);
  - the default IN_W/LANE_W/PEEK_W localparams;
  - a function computing bits-mod-8.
- One sub-module, decode_unpack_wbuf: the word buffer with lane indexer and in_ready logic. The window, FSM and flags stay in the top.

## Test plan
- Reset, then word 64'h...F0DE_BC9A_7856_3412:
  - out_valid=1 one cycle after accept;
  - out_data=13'h0246;
  - out_bits=16 then 32.
- Hold take=1 with width 13 over 4 back-to-back words → bit-exact against the reference serializer, with no out_valid gaps.
- take width 7 with align=1 (ALIGN_EN defined) → window advances 8 bits; out_bits is a multiple of 8. Same stimulus with the macro undefined → 7 bits consumed.
- Single in_last word with consumption to empty:
  - DRAIN entered;
  - final out_data has zero-filled low bits;
  - done pulses exactly once;
  - in_ready=1 in IDLE.
- take width 13 with out_bits=5 in DRAIN → out_bits=0, err_over=1 and it stays set.
- Assert rst mid-word → all outputs at reset values on the next cycle; a new stream then decodes correctly.
